// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle seen by one memory slave: address/data phase inputs plus
// the slave's ready, response and read data.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word array with byte-lane writes, WAIT_STATES wait cycles
// per OKAY data phase. Define AHB_SRAM_ERR_EN to answer illegal sizes/alignments with ERROR.
module ahb_sram_slave #(
    parameter int MEM_AW      = 13,
    parameter int WAIT_STATES = 1
) (
    input  logic                hclk,
    input  logic                hreset,
    ahb_sram_slave_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state, state_n;
    logic [2:0]          wcnt, wcnt_n;
    logic                load;

    logic [MEM_AW-1:0]   a_idx;
    logic [3:0]          a_be;
    logic                a_write;

    logic                accept;
    logic                illegal;
    logic [3:0]          be;

    logic [31:0]         mem [2**MEM_AW];

    logic                unused_bits;
    assign unused_bits = ^{bus.haddr[31:MEM_AW+2], bus.htrans[0]};

    assign accept = bus.hsel & bus.htrans[1] & bus.hready;

`ifdef AHB_SRAM_ERR_EN
    assign illegal = (bus.hsize > 3'd2)
                   | ((bus.hsize == 3'd1) & bus.haddr[0])
                   | ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00));
`else
    assign illegal = 1'b0;
`endif

    // Oversized accesses fall through to a full-word write.
    always_comb begin
        be = 4'b1111;
        case (bus.hsize)
            3'd0:    be = 4'b0001 << bus.haddr[1:0];
            3'd1:    be = bus.haddr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        load    = 1'b0;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                state_n = S_IDLE;
                if (accept) begin
                    load = 1'b1;
                    if (illegal) begin
                        state_n = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_n = S_WAIT;
                        wcnt_n  = 3'(WAIT_STATES - 1);
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt == 3'd0) state_n = S_DATA;
                else              wcnt_n  = wcnt - 3'd1;
            end
            S_ERR1:  state_n = S_ERR2;
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= S_IDLE;
            wcnt    <= 3'd0;
            a_idx   <= '0;
            a_be    <= 4'b0000;
            a_write <= 1'b0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (load) begin
                a_idx   <= bus.haddr[MEM_AW+1:2];
                a_be    <= be;
                a_write <= bus.hwrite;
            end
        end
    end

    // NOTE: the array has no reset; clearing it would force a flop-based
    // implementation instead of an SRAM macro, and contents survive reset.
    always_ff @(posedge hclk) begin
        if (state == S_DATA && a_write) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) mem[a_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
        end
    end

    assign bus.hreadyout = !(state == S_WAIT || state == S_ERR1);

`ifdef AHB_SRAM_ERR_EN
    assign bus.hresp = (state == S_ERR1) || (state == S_ERR2);
`else
    assign bus.hresp = 1'b0;
`endif

    assign bus.hrdata = (!a_write && (state == S_WAIT || state == S_DATA))
                      ? mem[a_idx] : 32'h0;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite memory slave that answers the HSEL produced by the system address decoder; instantiated behind HSEL1 (0x1000_0000, 32 KB window).
- Captures the address phase, inserts programmable wait states, and completes reads/writes to an internal word array with byte-lane writes.
- Returns two-cycle ERROR responses for illegal transfers when the error feature is compiled in.

Parameters:
- MEM_AW, 13, word-address bits; depth = 2^MEM_AW 32-bit words (default 32 KB).
- WAIT_STATES, 1, wait cycles inserted per OKAY data phase; legal range 0..7.

Ports:
- HCLK  input  1  clock; all state on rising edge.
- HRESET  input  1  asynchronous active-high reset.
- HSEL  input  1  slave select from address decoder.
- HADDR  input  32  byte address; only bits [MEM_AW+1:0] used.
- HTRANS  input  2  transfer type; bit1 = NONSEQ/SEQ.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
- HWDATA  input  32  write data, valid in data phase.
- HREADY  input  1  bus-level ready (muxed HREADYOUT of all slaves).
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- HRDATA  output  32  read data.

Behaviour:
- Accept condition: HSEL & HTRANS[1] & HREADY at a rising edge. On accept, register the address phase: word index HADDR[MEM_AW+1:2], HADDR[1:0], HWRITE, HSIZE.
- HSEL with HTRANS IDLE/BUSY, or HSEL low: no transfer. The next data phase is zero-wait OKAY.
- Address bits above MEM_AW+1 are ignored, so addresses alias modulo the memory size.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accept of a legal transfer goes to WAIT if WAIT_STATES>0, else to DATA. Accept of an illegal transfer goes to ERR1.
  - WAIT: HREADYOUT=0. Down-counter is loaded with WAIT_STATES-1 on accept and decrements each cycle; at 0 go to DATA.
  - DATA: HREADYOUT=1, HRESP=0. The transfer completes at this edge. A write commits here. A new accept in the same cycle re-enters WAIT/DATA/ERR1 back-to-back; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. Accept is handled as in DATA, otherwise go to IDLE.
- Total data-phase length: WAIT_STATES+1 cycles for OKAY; always 2 cycles for ERROR, with no wait states added.
- Write byte lanes (little-endian):
  - HSIZE=0: lane HADDR[1:0].
  - HSIZE=1: lanes {HADDR[1],0} and {HADDR[1],1}.
  - HSIZE=2: all four lanes.
  - Unselected bytes are unchanged.
- Reads:
  - HRDATA = mem[registered index] (full word, combinational read) whenever the registered transfer is a read and the state is WAIT or DATA; otherwise 0.
  - A read that immediately follows a write to the same word returns the new data, because the write commits at the edge that starts the read data phase.
- Reset (async, any state): state returns to IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter cleared. A write whose data phase was in progress is dropped. Memory contents are not reset.

Optional Feature:
- Macro: AHB_SRAM_ERR_EN.
- Defined: a transfer is illegal if HSIZE>2, or HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]!=0. Illegal transfers take the ERR1→ERR2 path and memory is untouched.
- Undefined: no illegal transfers exist and HRESP is tied 0. HSIZE>2 is treated as a word access, and misaligned low address bits are ignored for lane selection. This means the halfword lane uses HADDR[1] only, and a word access writes all lanes.

Test Plan:
- Word write then read, WAIT_STATES=1: write 0xDEADBEEF to 0x1000_0010, then read 0x1000_0010. Each data phase has exactly 1 HREADYOUT-low cycle; HRDATA=0xDEADBEEF, HRESP=0.
- Byte lanes, WAIT_STATES=0: word write 0x00000000 to 0x1000_0020, then byte write 0xAA to 0x...21, then halfword write 0x5566 to 0x...22. A read of 0x...20 returns 0x5566AA00; all phases are zero-wait.
- Back-to-back pipelining: write 0x11111111 to A, immediately followed by a read of A with no idle cycle. The read returns 0x11111111, with no missing or extra wait cycles.
- Aliasing and idle: write 0x12345678 to 0x1000_8004 (wraps to word 1), then read 0x1000_0004 and get 0x12345678. A cycle with HSEL=1 and HTRANS=IDLE gives HREADYOUT=1, HRESP=0, and no memory change.
- ERR_EN defined: word write to 0x1000_0002 gives cycle 1 HREADYOUT=0/HRESP=1 and cycle 2 HREADYOUT=1/HRESP=1; a subsequent read shows the word unchanged. With the macro undefined, the same access is OKAY and writes word 0.
- Async reset mid-WAIT, WAIT_STATES=3: assert HRESET during the second wait cycle of a write. HREADYOUT=1, HRESP=0, HRDATA=0 immediately, and the target word is unchanged afterwards.
